// File: rtl/sram_like_pkg.sv
// Shared types for the SRAM-like data bus responder: size codes, response entry, lane merge.
// No logic of its own; imported by the responder and its queue user.
// No flow control here; definitions only.
package sram_like_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
    } resp_entry_t;

    localparam int WAIT_W = 4;

    // Byte-lane merge of a lane-replicated store into the existing word.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Generic synchronous FIFO of DEPTH entries of type T, head visible combinationally.
// Latency: pushed entry is at the head the cycle after the push edge when empty.
// Backpressure: full/empty flags; pushes while full and pops while empty are ignored.
module resp_fifo #(
    parameter int   DEPTH = 2,
    parameter type  T     = logic [31:0],
    localparam int  PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  T              push_dat,
    input  logic          pop,
    output T              head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_incr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = store[rd_ptr];

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_incr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_incr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_slave.sv
// Responder for the data-side SRAM-like bus: word memory, in-order completion queue.
// Latency: data_ok in the cycle after edge T+RESP_DELAY for a request accepted at T into an empty queue.
// Backpressure: addr_ok = ~full & ~stall; the master always takes data_ok.
module data_sram_slave
    import sram_like_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int OUTSTANDING = 2,
    parameter int RESP_DELAY  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int                CW    = $clog2(OUTSTANDING + 1);
    localparam logic [WAIT_W-1:0] DELAY = WAIT_W'(RESP_DELAY);

    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  handshake;
    resp_entry_t           push_entry;
    resp_entry_t           head;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic                  pop;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  new_head;
    logic                  unused_bits;

    // Size is informational and upper/low address bits wrap away.
    assign unused_bits = ^{size, addr[31:DEPTH_LOG2+2], addr[1:0]};

    assign idx       = addr[DEPTH_LOG2+1:2];
    assign addr_ok   = ~full & ~stall;
    assign handshake = req & addr_ok;

    always_ff @(posedge clk) begin
        if (handshake & wr) begin
            mem[idx] <= merge_lanes(mem[idx], wdata, wstrb);
        end
    end

    // Loads capture the word at acceptance, so earlier stores are already visible.
    always_comb begin
        push_entry      = '0;
        push_entry.wr   = wr;
        push_entry.data = wr ? 32'h0 : mem[idx];
    end

    resp_fifo #(
        .DEPTH (OUTSTANDING),
        .T     (resp_entry_t)
    ) u_resp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (handshake),
        .push_dat (push_entry),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign data_ok = ~empty & (wait_cnt == '0);
    assign pop     = data_ok;
    assign rdata   = data_ok ? head.data : 32'h0;

    // A fresh head appears on a push into empty, or on a pop that leaves something behind.
    assign new_head = (handshake & empty) |
                      (pop & ((count > CW'(1)) | handshake));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (new_head) begin
            wait_cnt <= DELAY;
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed bench for data_sram_slave: three instances at response delays 0, 3 and 5.
// Only the instance selected by sel sees req; outputs are sampled on the falling edge.
module tb_data_sram_slave;
    import sram_like_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        stall;
    int          sel;
    logic [2:0]  reqv;
    logic [2:0]  aok;
    logic [2:0]  dok;
    logic [31:0] rd [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign reqv = {req & (sel == 2), req & (sel == 1), req & (sel == 0)};

    data_sram_slave #(.DEPTH_LOG2(10), .OUTSTANDING(2), .RESP_DELAY(0)) u_d0 (
        .clk(clk), .reset(reset), .req(reqv[0]), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .stall(stall),
        .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]));

    data_sram_slave #(.DEPTH_LOG2(10), .OUTSTANDING(2), .RESP_DELAY(3)) u_d3 (
        .clk(clk), .reset(reset), .req(reqv[1]), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .stall(stall),
        .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]));

    data_sram_slave #(.DEPTH_LOG2(10), .OUTSTANDING(2), .RESP_DELAY(5)) u_d5 (
        .clk(clk), .reset(reset), .req(reqv[2]), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .stall(stall),
        .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rd[2]));

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request to instance s, then d quiet cycles, then the completion.
    task automatic xfer(input int s, input bit w, input logic [31:0] a, input logic [3:0] st,
                        input logic [31:0] dat, input logic [31:0] exp, input int d,
                        input string nm);
        sel = s; req = 1'b1; wr = w; size = SZ_W; addr = a; wstrb = st; wdata = dat;
        @(negedge clk);
        chk({nm, " addr_ok"}, 32'(aok[s]), 32'd1);
        tick();
        req = 1'b0;
        for (int k = 0; k < d; k++) begin
            @(negedge clk);
            chk({nm, " early data_ok"}, 32'(dok[s]), 32'd0);
            tick();
        end
        @(negedge clk);
        chk({nm, " data_ok"}, 32'(dok[s]), 32'd1);
        chk({nm, " rdata"}, rd[s], exp);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t, required finish well before", $time);
        $fatal(1);
    end

    initial begin
        bit   exp_aok [14] = '{1,1,0,0,0,1,0,0,0,1,0,0,0,1};
        bit   exp_dok [14] = '{0,0,0,0,1,0,0,0,1,0,0,0,1,0};
        int   acc;
        int   pops;
        logic [31:0] tp_exp [8];

        tbl[0]  = '{1'b1, 32'h0000_0100, 4'hF, 32'h1122_3344, 32'h0};
        tbl[1]  = '{1'b1, 32'h0000_0100, 4'h2, 32'hAAAA_AAAA, 32'h0};
        tbl[2]  = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,         32'h1122_AA44};
        tbl[3]  = '{1'b1, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 32'h0};
        tbl[4]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0,         32'hDEAD_BEEF};
        tbl[5]  = '{1'b1, 32'h0000_0200, 4'hF, 32'h0,         32'h0};
        tbl[6]  = '{1'b1, 32'h0000_0202, 4'hC, 32'h5566_5566, 32'h0};
        tbl[7]  = '{1'b1, 32'h0000_0201, 4'h2, 32'h7777_7777, 32'h0};
        tbl[8]  = '{1'b0, 32'h0000_0203, 4'h0, 32'h0,         32'h5566_7700};
        tbl[9]  = '{1'b0, 32'hFFFF_F200, 4'h0, 32'h0,         32'h5566_7700};
        tbl[10] = '{1'b1, 32'h0000_0104, 4'hF, 32'hCAFE_F00D, 32'h0};
        tbl[11] = '{1'b0, 32'h0000_0104, 4'h0, 32'h0,         32'hCAFE_F00D};

        reset = 1'b1; req = 1'b0; wr = 1'b0; size = SZ_W; addr = '0;
        wstrb = '0; wdata = '0; stall = 1'b0; sel = 0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        chk("reset addr_ok", 32'(aok), 32'h7);
        chk("reset data_ok", 32'(dok), 32'h0);
        for (int i = 0; i < 3; i++) chk($sformatf("reset rdata%0d", i), rd[i], 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Table: lane merge, wrap, address low/high bits ignored
        for (int i = 0; i < 12; i++) begin
            xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].wstrb, tbl[i].wdata, tbl[i].exp, 0,
                 $sformatf("vec%0d", i));
        end

        // Throughput: 8 back-to-back loads at zero delay
        for (int i = 0; i < 8; i++) tp_exp[i] = (i % 2 == 1) ? 32'hCAFE_F00D : 32'h1122_AA44;
        sel = 0; wr = 1'b0; req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            addr = (i % 2 == 1) ? 32'h104 : 32'h100;
            @(negedge clk);
            chk($sformatf("tput addr_ok%0d", i), 32'(aok[0]), 32'd1);
            chk($sformatf("tput data_ok%0d", i), 32'(dok[0]), (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) chk($sformatf("tput rdata%0d", i - 1), rd[0], tp_exp[i - 1]);
            tick();
        end
        req = 1'b0;
        @(negedge clk);
        chk("tput data_ok7", 32'(dok[0]), 32'd1);
        chk("tput rdata7", rd[0], tp_exp[7]);
        tick();
        @(negedge clk);
        chk("tput idle", 32'(dok[0]), 32'd0);
        tick();

        // Stall input holds addr_ok low
        sel = 0; stall = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall addr_ok%0d", i), 32'(aok[0]), 32'd0);
            chk($sformatf("stall data_ok%0d", i), 32'(dok[0]), 32'd0);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall addr_ok", 32'(aok[0]), 32'd1);
        tick();
        req = 1'b0;
        @(negedge clk);
        chk("unstall data_ok", 32'(dok[0]), 32'd1);
        chk("unstall rdata", rd[0], 32'h1122_AA44);
        tick();

        // Back-pressure at delay 3 with continuous stores
        sel = 1; req = 1'b1; wr = 1'b1; addr = 32'h300; wstrb = 4'hF; wdata = 32'h5A5A_5A5A;
        acc = 0; pops = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            chk($sformatf("bp addr_ok c%0d", c), 32'(aok[1]), 32'(exp_aok[c]));
            chk($sformatf("bp data_ok c%0d", c), 32'(dok[1]), 32'(exp_dok[c]));
            if (dok[1]) chk($sformatf("bp rdata c%0d", c), rd[1], 32'h0);
            acc  += int'(aok[1]);
            pops += int'(dok[1]);
            tick();
        end
        req = 1'b0;
        chk("bp acceptances", acc, 5);
        chk("bp pops", pops, 3);

        // Reset mid-operation at delay 5
        xfer(2, 1'b1, 32'h400, 4'hF, 32'h1357_9BDF, 32'h0, 5, "d5 store");
        sel = 2; req = 1'b1; wr = 1'b0; addr = 32'h400;
        @(negedge clk);
        chk("rst ld0 addr_ok", 32'(aok[2]), 32'd1);
        tick();
        @(negedge clk);
        chk("rst ld1 addr_ok", 32'(aok[2]), 32'd1);
        tick();
        req = 1'b0;
        @(negedge clk);
        chk("rst full addr_ok", 32'(aok[2]), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst data_ok", 32'(dok[2]), 32'd0);
        chk("rst rdata", rd[2], 32'h0);
        tick();
        reset = 1'b0;
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pops += int'(dok[2]);
            chk($sformatf("post-rst addr_ok c%0d", c), 32'(aok[2]), 32'd1);
            tick();
        end
        chk("post-rst stray data_ok", pops, 0);

        // Queue count must be zero: two new accepts are needed to fill it
        req = 1'b1;
        @(negedge clk);
        chk("refill addr_ok0", 32'(aok[2]), 32'd1);
        tick();
        @(negedge clk);
        chk("refill addr_ok1", 32'(aok[2]), 32'd1);
        tick();
        req = 1'b0;
        @(negedge clk);
        chk("refill full", 32'(aok[2]), 32'd0);
        tick();
        pops = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (dok[2]) begin
                pops++;
                chk("refill rdata", rd[2], 32'h1357_9BDF);
            end
            tick();
        end
        chk("refill responses", pops, 2);
        xfer(2, 1'b0, 32'h400, 4'h0, 32'h0, 32'h1357_9BDF, 5, "post-rst load");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
